// File: rtl/wsc_pkg.sv
// wsc_pkg: shared types and helpers for the wolf/sheep/cabbage crossing monitor.
//   wsc_state_t  : packed {t, w, s, c} model state, 1 = far bank
//   wsc_fault_e  : fault codes reported on fault_code
//   wsc_move_e   : item inferred to have crossed with the farmer
//   WSC_SOLVED   : every item and the farmer on the far bank
//   wsc_unsafe() : a bank is unsafe with wolf+sheep or sheep+cabbage left without the farmer
//   wsc_moved()  : decode the item bits of a state delta
package wsc_pkg;

   typedef struct packed {
      logic t;
      logic w;
      logic s;
      logic c;
   } wsc_state_t;

   typedef enum logic [2:0] {
      F_NONE     = 3'd0,
      F_START    = 3'd1,
      F_NO_CROSS = 3'd2,
      F_MULTI    = 3'd3,
      F_STRAND   = 3'd4,
      F_UNSAFE   = 3'd5,
      F_TIMEOUT  = 3'd6
   } wsc_fault_e;

   typedef enum logic [2:0] {
      MV_NONE  = 3'd0,
      MV_W     = 3'd1,
      MV_S     = 3'd2,
      MV_C     = 3'd3,
      MV_MULTI = 3'd4
   } wsc_move_e;

   localparam wsc_state_t WSC_SOLVED = 4'b1111;

   function automatic logic wsc_unsafe(input wsc_state_t n);
      return ((n.w == n.s) && (n.t != n.s)) || ((n.s == n.c) && (n.t != n.s));
   endfunction

   // d holds the {w, s, c} delta bits only; the farmer bit is checked separately
   function automatic wsc_move_e wsc_moved(input logic [2:0] d);
      case (d)
         3'b000:  return MV_NONE;
         3'b100:  return MV_W;
         3'b010:  return MV_S;
         3'b001:  return MV_C;
         default: return MV_MULTI;
      endcase
   endfunction

endpackage

// File: rtl/wsc_visited.sv
// wsc_visited: 16-entry visited-state bitmap.
//   clk, rst (sync, active-low)
//   clr     : clear every entry; a simultaneous set_en still marks set_idx
//   set_en  : mark set_idx as visited at the edge
//   set_idx : state index to mark and to look up
//   hit     : combinational read of the entry at set_idx (value before this edge)
module wsc_visited (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       set_en,
   input  logic [3:0] set_idx,
   output logic       hit
);

   logic [15:0] map_q;
   logic [15:0] map_nxt;

   always_comb begin
      map_nxt = clr ? 16'h0000 : map_q;
      if (set_en) map_nxt[set_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) map_q <= 16'h0000;
      else      map_q <= map_nxt;
   end

   assign hit = map_q[set_idx];

endmodule

// File: rtl/wsc_monitor.sv
// wsc_monitor: run-time rule checker for the wolf/sheep/cabbage crossing model.
//   clk, rst (sync, active-low)
//   start      : arm pulse, priority over all checks; state_i must be 0000
//   state_i    : model state {t, w, s, c}
//   busy       : in RUN
//   solved     : in SOLVED
//   fault      : in FAULT
//   fault_code : wsc_fault_e code of the latched fault
//   cross_cnt  : legal crossings since the last start
//   revisit    : sticky, a state was re-entered during this run
//
// state  | meaning
// IDLE   | after reset, waiting for start; state_i ignored
// RUN    | checking one crossing per edge
// SOLVED | reached 1111; outputs hold until start/reset
// FAULT  | rule broken or crossing budget used up; outputs hold
module wsc_monitor
   import wsc_pkg::*;
#(
   parameter int CNT_W = 6,
   parameter int LIMIT = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       state_i,
   output logic             busy,
   output logic             solved,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic [CNT_W-1:0] cross_cnt,
   output logic             revisit
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_SOLVED = 2'd2;
   localparam logic [1:0] S_FAULT  = 2'd3;

   logic [1:0]       st_q;
   wsc_state_t       prev_q;
   wsc_fault_e       code_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rev_q;

   wsc_state_t       cur;
   logic [3:0]       d;
   wsc_move_e        mv;
   wsc_fault_e       chk;
   logic             stranded;
   logic [CNT_W-1:0] cnt_nxt;
   logic             vis_set;
   logic             vis_hit;

   assign cur     = state_i;
   assign d       = state_i ^ prev_q;
   assign mv      = wsc_moved(d[2:0]);
   assign cnt_nxt = cnt_q + 1'b1;

   // the moved item has to start on the farmer's bank
   always_comb begin
      stranded = 1'b0;
      case (mv)
         MV_W:    stranded = (prev_q.w != prev_q.t);
         MV_S:    stranded = (prev_q.s != prev_q.t);
         MV_C:    stranded = (prev_q.c != prev_q.t);
         default: stranded = 1'b0;
      endcase
   end

   always_comb begin
      chk = F_NONE;
      if (!d[3])                chk = F_NO_CROSS;
      else if (mv == MV_MULTI)  chk = F_MULTI;
      else if (stranded)        chk = F_STRAND;
      else if (wsc_unsafe(cur)) chk = F_UNSAFE;
   end

   assign vis_set = start || ((st_q == S_RUN) && (chk == F_NONE));

   wsc_visited u_visited (
      .clk     (clk),
      .rst     (rst),
      .clr     (start),
      .set_en  (vis_set),
      .set_idx (state_i),
      .hit     (vis_hit)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q   <= S_IDLE;
         prev_q <= '0;
         code_q <= F_NONE;
         cnt_q  <= '0;
         rev_q  <= 1'b0;
      end else if (start) begin
         prev_q <= cur;
         cnt_q  <= '0;
         rev_q  <= 1'b0;
         if (state_i != 4'b0000) begin
            st_q   <= S_FAULT;
            code_q <= F_START;
         end else begin
            st_q   <= S_RUN;
            code_q <= F_NONE;
         end
      end else if (st_q == S_RUN) begin
         if (chk != F_NONE) begin
            st_q   <= S_FAULT;
            code_q <= chk;
         end else begin
            cnt_q  <= cnt_nxt;
            prev_q <= cur;
            if (vis_hit) rev_q <= 1'b1;
            // solving on the last allowed crossing is still a solve
            if (cur == WSC_SOLVED) begin
               st_q <= S_SOLVED;
            end else if (cnt_nxt == CNT_W'(LIMIT)) begin
               st_q   <= S_FAULT;
               code_q <= F_TIMEOUT;
            end
         end
      end
   end

   assign busy       = (st_q == S_RUN);
   assign solved     = (st_q == S_SOLVED);
   assign fault      = (st_q == S_FAULT);
   assign fault_code = code_q;
   assign cross_cnt  = cnt_q;
   assign revisit    = rev_q;

endmodule

// File: tb/tb_wsc_monitor.sv
module tb_wsc_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] state_i;

   logic       busy_a, solved_a, fault_a, rev_a;
   logic [2:0] code_a;
   logic [5:0] cnt_a;
   logic       busy_b, solved_b, fault_b, rev_b;
   logic [2:0] code_b;
   logic [5:0] cnt_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [12:0] exp_q[$];

   always #5 clk = ~clk;

   // LIMIT=7 makes the optimal 7-crossing solve coincide with the timeout count
   wsc_monitor #(.CNT_W(6), .LIMIT(7)) dut_a (
      .clk(clk), .rst(rst), .start(start), .state_i(state_i),
      .busy(busy_a), .solved(solved_a), .fault(fault_a),
      .fault_code(code_a), .cross_cnt(cnt_a), .revisit(rev_a)
   );

   wsc_monitor #(.CNT_W(6), .LIMIT(3)) dut_b (
      .clk(clk), .rst(rst), .start(start), .state_i(state_i),
      .busy(busy_b), .solved(solved_b), .fault(fault_b),
      .fault_code(code_b), .cross_cnt(cnt_b), .revisit(rev_b)
   );

   wire [12:0] obs_a = {busy_a, solved_a, fault_a, code_a, cnt_a, rev_a};
   wire [12:0] obs_b = {busy_b, solved_b, fault_b, code_b, cnt_b, rev_b};

   // expected output word {busy, solved, fault, code, cnt, revisit}
   function automatic logic [12:0] mk(bit b, bit s, bit f, int code, int cnt, bit rv);
      return {b, s, f, 3'(code), 6'(cnt), rv};
   endfunction

   // drive one cycle of stimulus, queue its expected outcome, sample after the edge
   task automatic step(input logic r, input logic st, input logic [3:0] s, input logic [12:0] e);
      rst     = r;
      start   = st;
      state_i = s;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [12:0] e;
      for (int i = 0; i < 4; i++) begin
         // two cycles in reset, then two idle cycles with no start
         step(i >= 2, 1'b0, 4'($urandom_range(15)), mk(0, 0, 0, 0, 0, 0));
         e = exp_q.pop_front();
         n_checks++;
         if (obs_a !== e) begin
            n_fail++;
            $display("FAIL reset step %0d: got %h expected %h", i, obs_a, e);
         end
      end
   endtask

   task automatic test_optimal;
      logic [3:0]  seq [0:8];
      logic [12:0] ex  [0:8];
      logic [12:0] e;
      seq = '{4'b0000, 4'b1010, 4'b0010, 4'b1110, 4'b0100, 4'b1101, 4'b0101, 4'b1111, 4'b0110};
      ex  = '{mk(1,0,0,0,0,0), mk(1,0,0,0,1,0), mk(1,0,0,0,2,0), mk(1,0,0,0,3,0),
              mk(1,0,0,0,4,0), mk(1,0,0,0,5,0), mk(1,0,0,0,6,0), mk(0,1,0,0,7,0),
              mk(0,1,0,0,7,0)};
      for (int i = 0; i < 9; i++) begin
         step(1'b1, i == 0, seq[i], ex[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_a !== e) begin
            n_fail++;
            $display("FAIL optimal step %0d: got %h expected %h", i, obs_a, e);
         end
      end
   endtask

   task automatic test_unsafe;
      logic [3:0]  seq [0:2];
      logic [12:0] ex  [0:2];
      logic [12:0] e;
      seq = '{4'b0000, 4'b1000, 4'b1010};
      ex  = '{mk(1,0,0,0,0,0), mk(0,0,1,5,0,0), mk(0,0,1,5,0,0)};
      for (int i = 0; i < 3; i++) begin
         step(1'b1, i == 0, seq[i], ex[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_a !== e) begin
            n_fail++;
            $display("FAIL unsafe step %0d: got %h expected %h", i, obs_a, e);
         end
      end
   endtask

   task automatic test_multi_nocross;
      logic [3:0]  seq [0:3];
      logic [12:0] ex  [0:3];
      logic [12:0] e;
      seq = '{4'b0000, 4'b1110, 4'b0000, 4'b0100};
      ex  = '{mk(1,0,0,0,0,0), mk(0,0,1,3,0,0), mk(1,0,0,0,0,0), mk(0,0,1,2,0,0)};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, i == 0 || i == 2, seq[i], ex[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_a !== e) begin
            n_fail++;
            $display("FAIL multi_nocross step %0d: got %h expected %h", i, obs_a, e);
         end
      end
   endtask

   task automatic test_strand;
      logic [3:0]  seq [0:3];
      logic [12:0] ex  [0:3];
      logic [12:0] e;
      seq = '{4'b0000, 4'b1010, 4'b0110, 4'b1111};
      ex  = '{mk(1,0,0,0,0,0), mk(1,0,0,0,1,0), mk(0,0,1,4,1,0), mk(0,0,1,4,1,0)};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, i == 0, seq[i], ex[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_a !== e) begin
            n_fail++;
            $display("FAIL strand step %0d: got %h expected %h", i, obs_a, e);
         end
      end
   endtask

   task automatic test_revisit_timeout;
      logic [3:0]  seq [0:4];
      logic [12:0] ex  [0:4];
      logic [12:0] e;
      seq = '{4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b0000};
      ex  = '{mk(1,0,0,0,0,0), mk(1,0,0,0,1,0), mk(1,0,0,0,2,1), mk(0,0,1,6,3,1),
              mk(0,0,1,6,3,1)};
      for (int i = 0; i < 5; i++) begin
         step(1'b1, i == 0, seq[i], ex[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_b !== e) begin
            n_fail++;
            $display("FAIL revisit_timeout step %0d: got %h expected %h", i, obs_b, e);
         end
      end
   endtask

   // dut_a sits in FAULT (STRAND) from the previous run when this starts
   task automatic test_priority;
      logic [12:0] e;
      logic        r   [0:5];
      logic        st  [0:5];
      logic [3:0]  seq [0:5];
      logic [12:0] ex  [0:5];
      r   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      st  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      seq = '{4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b0000};
      ex  = '{mk(1,0,0,0,0,0), mk(1,0,0,0,1,0), mk(0,0,0,0,0,0), mk(0,0,0,0,0,0),
              mk(0,0,1,1,0,0), mk(0,0,1,1,0,0)};
      for (int i = 0; i < 6; i++) begin
         step(r[i], st[i], seq[i], ex[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_a !== e) begin
            n_fail++;
            $display("FAIL priority step %0d: got %h expected %h", i, obs_a, e);
         end
      end
   endtask

   initial begin
      rst     = 1'b0;
      start   = 1'b0;
      state_i = 4'b0000;
      @(posedge clk);
      #1;
      test_reset();
      test_optimal();
      test_unsafe();
      test_multi_nocross();
      test_strand();
      test_priority();
      test_revisit_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
